// File: rtl/timer_pkg.sv
// Shared definitions for the keypad time-entry path: digit width, key codes, FSM states.
package timer_pkg;

  localparam int unsigned     BCD_W      = 4;
  localparam int unsigned     MAX_DIGITS = 4;
  localparam logic [BCD_W-1:0] KEY_CLEAR = 4'hA;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is a one-cycle pulse the cycle after sig goes high.
module rise_detect (
  input  logic clock,
  input  logic clearn,
  input  logic sig,
  output logic rise
);

  logic sig_q, sig_d;
  logic rise_q, rise_d;

  always_comb begin
    sig_d  = sig;
    rise_d = sig & ~sig_q;
  end

  always_ff @(posedge clock) begin
    if (!clearn) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/keypad_entry.sv
// Collects BCD keypad digits into an MM:SS buffer and strobes loadn for one cycle to
// transfer it to the timer counters; keys and start are ignored while the timer runs.
module keypad_entry #(
  parameter int unsigned                  MAX_DIGITS = timer_pkg::MAX_DIGITS,
  parameter logic [timer_pkg::BCD_W-1:0]  KEY_CLEAR  = timer_pkg::KEY_CLEAR
) (
  input  logic                                   clock,
  input  logic                                   clearn,
  input  logic                                   key_valid,
  input  logic [timer_pkg::BCD_W-1:0]            key_code,
  input  logic                                   start,
  input  logic                                   timer_running,
  output logic [MAX_DIGITS*timer_pkg::BCD_W-1:0] digits,
  output logic                                   loadn,
  output logic [$clog2(MAX_DIGITS+1)-1:0]        digit_count,
  output logic                                   invalid
);

  import timer_pkg::*;

  localparam int unsigned      DW      = MAX_DIGITS * BCD_W;
  localparam int unsigned      CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  state_t           state_q, state_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loadn_q, loadn_d;
  logic [BCD_W-1:0] code_q, code_d;

  logic             key_rise;
  logic             key_acc;
  logic             start_ok;
  logic [DW-1:0]    shifted;

  rise_detect u_key_rise (
    .clock  (clock),
    .clearn (clearn),
    .sig    (key_valid),
    .rise   (key_rise)
  );

  // Track the code alongside the edge register so the accepted key matches the one
  // present when key_valid rose, even for single-cycle presses.
  always_comb begin
    code_d = key_valid ? key_code : code_q;
  end

  assign invalid  = digits_q[2*BCD_W-1:BCD_W] > 4'd5;
  assign key_acc  = key_rise & ~timer_running;
  assign start_ok = start & ~timer_running & ~invalid;
  assign shifted  = {digits_q[DW-BCD_W-1:0], code_q};

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;

    case (state_q)
      EMPTY: begin
        if (key_acc && is_digit(code_q)) begin
          digits_d = shifted;
          cnt_d    = CNT_W'(1);
          state_d  = ENTRY;
        end
      end

      ENTRY: begin
        // Start takes priority; a coincident key edge is discarded.
        if (start_ok) begin
          state_d = LOAD;
        end else if (key_acc) begin
          if (is_digit(code_q)) begin
            digits_d = shifted;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (code_q == KEY_CLEAR) begin
            digits_d = '0;
            cnt_d    = '0;
            state_d  = EMPTY;
          end
        end
      end

      LOAD: begin
        digits_d = '0;
        cnt_d    = '0;
        state_d  = EMPTY;
      end

      default: begin
        digits_d = '0;
        cnt_d    = '0;
        state_d  = EMPTY;
      end
    endcase

    loadn_d = (state_d != LOAD);
  end

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q  <= EMPTY;
      digits_q <= '0;
      cnt_q    <= '0;
      loadn_q  <= 1'b1;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      loadn_q  <= loadn_d;
      code_q   <= code_d;
    end
  end

  assign digits      = digits_q;
  assign digit_count = cnt_q;
  assign loadn       = loadn_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry; loads are scoreboarded against a queue of expected digit values.
module tb_keypad_entry;

  logic        clock;
  logic        clearn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        start;
  logic        timer_running;
  logic [15:0] digits;
  logic        loadn;
  logic [2:0]  digit_count;
  logic        invalid;

  int errors = 0;
  int checks = 0;
  int loads  = 0;
  logic [15:0] exp_load_q[$];

  keypad_entry dut (
    .clock         (clock),
    .clearn        (clearn),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .start         (start),
    .timer_running (timer_running),
    .digits        (digits),
    .loadn         (loadn),
    .digit_count   (digit_count),
    .invalid       (invalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    key_code  = code;
    key_valid = 1'b1;
    tick(hold);
    key_valid = 1'b0;
    tick(3);
  endtask

  // Every cycle with loadn low must match the next expected load value.
  always @(negedge clock) begin
    if (loadn === 1'b0) begin
      loads++;
      chk("load_pending", {31'd0, exp_load_q.size() != 0}, 32'd1);
      if (exp_load_q.size() != 0) chk("load_digits", {16'd0, digits}, {16'd0, exp_load_q.pop_front()});
    end
  end

  initial begin
    clearn        = 1'b0;
    key_valid     = 1'b0;
    key_code      = 4'h0;
    start         = 1'b0;
    timer_running = 1'b0;
    tick(3);
    chk("reset_digits", {16'd0, digits}, 32'h0);
    chk("reset_count", {29'd0, digit_count}, 32'd0);
    chk("reset_loadn", {31'd0, loadn}, 32'd1);
    chk("reset_invalid", {31'd0, invalid}, 32'd0);
    clearn = 1'b1;
    tick(1);

    // 1,2,3,0 with 3-cycle presses
    press(4'h1, 3);
    chk("first_digit_count", {29'd0, digit_count}, 32'd1);
    press(4'h2, 3);
    press(4'h3, 3);
    press(4'h0, 3);
    chk("four_digits", {16'd0, digits}, 32'h1230);
    chk("four_count", {29'd0, digit_count}, 32'd4);
    chk("no_load_during_entry", loads, 32'd0);

    // fifth digit held long: shifts once, count saturates
    press(4'h5, 10);
    chk("fifth_digits", {16'd0, digits}, 32'h2305);
    chk("fifth_count", {29'd0, digit_count}, 32'd4);

    press(4'hA, 2);
    chk("clear_digits", {16'd0, digits}, 32'h0);
    chk("clear_count", {29'd0, digit_count}, 32'd0);

    // start in EMPTY is ignored
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("start_empty_no_load", loads, 32'd0);

    press(4'h4, 1);
    press(4'h5, 2);
    press(4'hC, 2);
    chk("ignored_code_digits", {16'd0, digits}, 32'h0045);
    chk("ignored_code_count", {29'd0, digit_count}, 32'd2);

    exp_load_q.push_back(16'h0045);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("load_loadn_low", {31'd0, loadn}, 32'd0);
    chk("load_digits_held", {16'd0, digits}, 32'h0045);
    tick(1);
    chk("after_load_loadn", {31'd0, loadn}, 32'd1);
    chk("after_load_digits", {16'd0, digits}, 32'h0);
    chk("after_load_count", {29'd0, digit_count}, 32'd0);
    chk("one_load", loads, 32'd1);

    // sec_tens = 7 blocks start
    press(4'h0, 2);
    press(4'h7, 2);
    press(4'h0, 2);
    chk("invalid_digits", {16'd0, digits}, 32'h0070);
    chk("invalid_high", {31'd0, invalid}, 32'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("invalid_start_loadn", {31'd0, loadn}, 32'd1);
    tick(1);
    chk("invalid_start_digits", {16'd0, digits}, 32'h0070);
    chk("invalid_start_count", {29'd0, digit_count}, 32'd3);
    press(4'hA, 2);
    chk("invalid_cleared", {31'd0, invalid}, 32'd0);
    chk("invalid_clear_count", {29'd0, digit_count}, 32'd0);

    // start coincident with accepted key edge: start wins
    press(4'h1, 2);
    press(4'h2, 2);
    exp_load_q.push_back(16'h0012);
    key_code  = 4'h9;
    key_valid = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("race_loadn_low", {31'd0, loadn}, 32'd0);
    chk("race_digits_old", {16'd0, digits}, 32'h0012);
    tick(1);
    chk("race_after_digits", {16'd0, digits}, 32'h0);
    key_valid = 1'b0;
    tick(3);
    chk("race_key_dropped", {29'd0, digit_count}, 32'd0);
    chk("two_loads", loads, 32'd2);

    // timer running: keys and start ignored
    press(4'h3, 2);
    timer_running = 1'b1;
    press(4'h9, 3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("running_digits", {16'd0, digits}, 32'h0003);
    chk("running_count", {29'd0, digit_count}, 32'd1);
    chk("running_no_load", loads, 32'd2);
    timer_running = 1'b0;
    press(4'hA, 2);

    // reset asserted while in LOAD
    press(4'h4, 2);
    press(4'h5, 2);
    exp_load_q.push_back(16'h0045);
    start = 1'b1;
    tick(1);
    start  = 1'b0;
    clearn = 1'b0;
    chk("rst_load_loadn_low", {31'd0, loadn}, 32'd0);
    tick(1);
    chk("rst_load_loadn", {31'd0, loadn}, 32'd1);
    chk("rst_load_digits", {16'd0, digits}, 32'h0);
    chk("rst_load_count", {29'd0, digit_count}, 32'd0);
    clearn = 1'b1;
    tick(4);

    chk("load_total", loads, 32'd3);
    chk("load_q_empty", exp_load_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 4, the number of BCD digit positions held (MM:SS).
REQ-002 The block SHALL have parameter KEY_CLEAR, default 4'hA, the key code that empties the buffer.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 clearn  input  1  reset, synchronous, active-low.
REQ-005 key_valid  input  1  level from keypad encoder; high for one or more cycles per keypress.
REQ-006 key_code  input  4  code of the pressed key; 0-9 digits, KEY_CLEAR clear, others ignored.
REQ-007 start  input  1  request to transfer the entered time to the timer counters.
REQ-008 timer_running  input  1  high while the downstream counters are counting (their enable).
REQ-009 digits  output  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD, 4 bits each.
REQ-010 loadn  output  1  active-low load strobe to the downstream digit counters.
REQ-011 digit_count  output  3  number of digits entered, 0..MAX_DIGITS.
REQ-012 invalid  output  1  high while sec_tens > 5.

Function
REQ-013 A keypress SHALL be accepted only on the cycle after a rising edge of key_valid (registered edge detect); holding key_valid high SHALL NOT produce repeats.
REQ-014 An accepted digit 0-9 SHALL shift the buffer left one position: new digit into sec_ones, min_tens discarded.
REQ-015 digit_count SHALL increment on each accepted digit and saturate at MAX_DIGITS.
REQ-016 An accepted KEY_CLEAR SHALL set digits to 0 and digit_count to 0 on the next edge.
REQ-017 Accepted codes 4'hB-4'hF SHALL leave all state unchanged.
REQ-018 While timer_running=1, keypresses and start SHALL be ignored.
REQ-019 The FSM SHALL have states EMPTY (count=0), ENTRY (count>0), LOAD.
REQ-020 EMPTY->ENTRY on accepted digit; ENTRY->EMPTY on KEY_CLEAR; ENTRY->LOAD on start=1 with invalid=0 and timer_running=0.
REQ-021 start in EMPTY, or with invalid=1, SHALL be ignored.
REQ-022 LOAD SHALL last exactly one cycle with loadn=0 and digits held stable; LOAD->EMPTY with digits and count cleared on the following edge.
REQ-023 loadn SHALL be registered and low only in LOAD.
REQ-024 When start and a key edge occur in the same cycle in ENTRY, start SHALL win and the key SHALL be dropped.
REQ-025 Key edges arriving during LOAD SHALL be dropped.
REQ-026 invalid SHALL be combinational from the held sec_tens.

Reset
REQ-027 On clock edge with clearn=0: state EMPTY, digits=16'h0000, digit_count=0, loadn=1, edge-detect register=0.
REQ-028 Reset during LOAD SHALL force loadn=1 on that same edge; no further load occurs.

Structure
REQ-029 A shared package timer_pkg SHALL hold BCD_W=4, KEY_CLEAR, MAX_DIGITS and the FSM state type.
REQ-030 Rising-edge detection SHALL be one sub-module, rise_detect, instantiated for key_valid.

Verification
REQ-031 Press 1,2,3,0 (key_valid 3 cycles each) -> digits=16'h1230, digit_count=4, loadn=1 throughout.
REQ-032 Press 1,2,3,0,5 -> digits=16'h2305, digit_count=4.
REQ-033 After 16'h0045, pulse start -> loadn=0 for exactly one cycle with digits=16'h0045; next cycle digits=0, count=0.
REQ-034 Enter 0,7,0 (sec_tens=7) -> invalid=1; start -> loadn stays 1; KEY_CLEAR -> invalid=0, count=0.
REQ-035 start and key edge together in ENTRY -> single load of the old value; timer_running=1 with key 9 -> no change.
REQ-036 clearn=0 during LOAD -> loadn=1 and digits=0 at that edge.
